// File: rtl/ntt_pkg.sv
// Shared NTT constants, mode encodings and modular add/sub/halve helpers.
// Helpers work on 32-bit values, so WIDTH must stay below 31.
package ntt_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_Q     = 3329;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'b00,
        MODE_INTT = 2'b01,
        MODE_MUL  = 2'b10,
        MODE_BYP  = 2'b11
    } mode_e;

    typedef logic [31:0] modw_t;

    function automatic logic [63:0] barrett_k(input int width, input int q);
        return (64'd1 << (2 * width)) / 64'(q);
    endfunction

    localparam logic [63:0] BARRETT_K = barrett_k(DEFAULT_WIDTH, DEFAULT_Q);

    function automatic modw_t mod_add(input modw_t x, input modw_t y, input modw_t q);
        modw_t s;
        s = x + y;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic modw_t mod_sub(input modw_t x, input modw_t y, input modw_t q);
        return (x >= y) ? x - y : x + q - y;
    endfunction

    // Multiply by 2^-1 mod q (q odd): odd inputs become even once q is added.
    function automatic modw_t mod_half(input modw_t x, input modw_t q);
        return x[0] ? (x + q) >> 1 : x >> 1;
    endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// Two-stage modular multiplier: raw product register, then Barrett reduction
// with one conditional subtract into the result register.
module mod_mul_barrett
    import ntt_pkg::*;
#(
    parameter int          WIDTH = DEFAULT_WIDTH,
    parameter int          Q     = DEFAULT_Q,
    parameter logic [63:0] K     = BARRETT_K
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_r
);

    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_r;
    logic [2*WIDTH-1:0] w_qe;
    logic [WIDTH:0]     w_rem;

    // Quotient estimate is at most one short because the product is below 2^(2*WIDTH),
    // so the true remainder fits in WIDTH+1 bits and one subtract finishes it.
    assign w_qe  = (2*WIDTH)'(((4*WIDTH)'(r_p) * (4*WIDTH)'(K)) >> (2*WIDTH));
    assign w_rem = (WIDTH+1)'(r_p - w_qe * (2*WIDTH)'(Q));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_p <= '0;
            r_r <= '0;
        end else if (i_en) begin
            r_p <= (2*WIDTH)'(i_x) * (2*WIDTH)'(i_y);
            r_r <= (w_rem >= (WIDTH+1)'(Q)) ? WIDTH'(w_rem - (WIDTH+1)'(Q)) : WIDTH'(w_rem);
        end
    end

    assign o_r = r_r;

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage NTT/INTT/MUL/BYP butterfly with valid/ready and tag pass-through.
// Define BUTTERFLY_INTT_HALF_EN to scale both INTT outputs by 2^-1 mod Q.
module butterfly_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int Q     = DEFAULT_Q,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [TAG_W-1:0] out_tag
);

    localparam int    STAGES = 4;
    localparam modw_t QW     = modw_t'(Q);

    logic [STAGES:1]          r_vld_pipe;
    mode_e                    r1_mode, r2_mode, r3_mode;
    logic [WIDTH-1:0]         r1_a, r1_b, r1_w, r2_a, r2_b, r3_a, r3_b;
    logic [TAG_W-1:0]         r1_tag, r2_tag, r3_tag;
    logic [WIDTH-1:0]         r_c, r_d;
    logic [TAG_W-1:0]         r_tag;

    logic                     w_stall, w_en;
    logic [WIDTH-1:0]         w_sum, w_diff, w_c, w_d;
    logic [1:0][WIDTH-1:0]    w_my, w_mr;

    assign w_stall   = r_vld_pipe[STAGES] && !out_ready;
    assign w_en      = !w_stall;
    assign in_ready  = w_en;
    assign out_valid = r_vld_pipe[STAGES];
    assign c         = r_c;
    assign d         = r_d;
    assign out_tag   = r_tag;

    assign w_sum  = WIDTH'(mod_add(modw_t'(r1_a), modw_t'(r1_b), QW));
    assign w_diff = WIDTH'(mod_sub(modw_t'(r1_a), modw_t'(r1_b), QW));

    // Lane 0 carries the single product of NTT/INTT and a*w for MUL; lane 1 only b*w.
    always_comb begin
        w_my[0] = r1_b;
        w_my[1] = r1_b;
        case (r1_mode)
            MODE_INTT: w_my[0] = w_diff;
            MODE_MUL:  w_my[0] = r1_a;
            default:   ;
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_mul
        mod_mul_barrett #(
            .WIDTH (WIDTH),
            .Q     (Q),
            .K     (barrett_k(WIDTH, Q))
        ) u_mul (
            .i_clk (clk),
            .i_rst (rst),
            .i_en  (w_en),
            .i_x   (r1_w),
            .i_y   (w_my[gi]),
            .o_r   (w_mr[gi])
        );
    end

    // For INTT the b slot of stages 2-3 carries a+b, which becomes c directly.
    always_comb begin
        w_c = r3_a;
        w_d = r3_b;
        case (r3_mode)
            MODE_NTT: begin
                w_c = WIDTH'(mod_add(modw_t'(r3_a), modw_t'(w_mr[0]), QW));
                w_d = WIDTH'(mod_sub(modw_t'(r3_a), modw_t'(w_mr[0]), QW));
            end
            MODE_INTT: begin
                w_c = r3_b;
                w_d = w_mr[0];
            end
            MODE_MUL: begin
                w_c = w_mr[0];
                w_d = w_mr[1];
            end
            default: ;
        endcase
`ifdef BUTTERFLY_INTT_HALF_EN
        if (r3_mode == MODE_INTT) begin
            w_c = WIDTH'(mod_half(modw_t'(w_c), QW));
            w_d = WIDTH'(mod_half(modw_t'(w_d), QW));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r1_mode    <= MODE_NTT;
            r2_mode    <= MODE_NTT;
            r3_mode    <= MODE_NTT;
            r1_a       <= '0;
            r1_b       <= '0;
            r1_w       <= '0;
            r2_a       <= '0;
            r2_b       <= '0;
            r3_a       <= '0;
            r3_b       <= '0;
            r1_tag     <= '0;
            r2_tag     <= '0;
            r3_tag     <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_tag      <= '0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
            r1_mode    <= mode_e'(mode);
            r1_a       <= a;
            r1_b       <= b;
            r1_w       <= w;
            r1_tag     <= in_tag;
            r2_mode    <= r1_mode;
            r2_a       <= r1_a;
            r2_b       <= (r1_mode == MODE_INTT) ? w_sum : r1_b;
            r2_tag     <= r1_tag;
            r3_mode    <= r2_mode;
            r3_a       <= r2_a;
            r3_b       <= r2_b;
            r3_tag     <= r2_tag;
            r_c        <= w_c;
            r_d        <= w_d;
            r_tag      <= r3_tag;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors, a stalled stream,
// mid-stream reset and a long randomized run against a plain-arithmetic model.
module tb_butterfly_pipe;
    import ntt_pkg::*;

    localparam int Q     = 3329;
    localparam int WIDTH = 16;
    localparam int TAG_W = 8;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic [1:0]       mode      = '0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic [WIDTH-1:0] w         = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_ready = 1'b1;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] c, d;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .w(w), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .c(c), .d(d), .out_tag(out_tag)
    );

    typedef struct { int m; int a; int b; int w; int c; int d; } vec_t;
    typedef struct { int c; int d; int tag; } exp_t;

    int   errors   = 0;
    int   checks   = 0;
    int   acc_cnt  = 0;
    int   out_cnt  = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic held = 1'b0;
    int   hc, hd, ht;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference butterfly from the arithmetic definitions.
    function automatic void ref_bf(input int m, input int av, input int bv, input int wv,
                                   output int co, output int dout);
        int p;
        case (m)
            0: begin
                p    = (wv * bv) % Q;
                co   = (av + p) % Q;
                dout = (av - p + Q) % Q;
            end
            1: begin
                co   = (av + bv) % Q;
                dout = (wv * ((av - bv + Q) % Q)) % Q;
`ifdef BUTTERFLY_INTT_HALF_EN
                co   = (co * ((Q + 1) / 2)) % Q;
                dout = (dout * ((Q + 1) / 2)) % Q;
`endif
            end
            2: begin
                co   = (av * wv) % Q;
                dout = (bv * wv) % Q;
            end
            default: begin
                co   = av;
                dout = bv;
            end
        endcase
    endfunction

    function automatic int rnd_op();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return Q - 1;
            2:       return 1;
            default: return int'($urandom_range(0, Q - 1));
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard: every accepted beat is modelled, every delivered beat is popped in order.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_c", int'(c), hc);
                check("hold_d", int'(d), hd);
                check("hold_tag", int'(out_tag), ht);
            end
            if (out_valid) begin
                checks++;
                if (c >= Q || d >= Q) begin
                    errors++;
                    $display("FAIL range: got c=%0d d=%0d required below %0d", c, d, Q);
                end
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got tag %0d with no beat outstanding", out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_c", int'(c), mon_e.c);
                    check("out_d", int'(d), mon_e.d);
                    check("out_tag", int'(out_tag), mon_e.tag);
                end
            end
            held = out_valid && !out_ready;
            hc   = int'(c);
            hd   = int'(d);
            ht   = int'(out_tag);
            if (in_valid && in_ready) begin
                ref_bf(int'(mode), int'(a), int'(b), int'(w), mon_e.c, mon_e.d);
                mon_e.tag = int'(in_tag);
                sb.push_back(mon_e);
                acc_cnt++;
            end
        end
    end

    task automatic drive(input int m, input int av, input int bv, input int wv, input int tg);
        mode     = 2'(m);
        a        = WIDTH'(av);
        b        = WIDTH'(bv);
        w        = WIDTH'(wv);
        in_tag   = TAG_W'(tg);
        in_valid = 1'b1;
    endtask

    // Beat driven after edge n is captured at edge n+1 and shows after edge n+4.
    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive(v.m, v.a, v.b, v.w, idx);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
            if (k < 4) begin
                check($sformatf("vec%0d_lat_idle", idx), int'(out_valid), 0);
            end else begin
                check($sformatf("vec%0d_lat_valid", idx), int'(out_valid), 1);
                check($sformatf("vec%0d_c", idx), int'(c), v.c);
                check($sformatf("vec%0d_d", idx), int'(d), v.d);
                check($sformatf("vec%0d_tag", idx), int'(out_tag), idx);
            end
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    initial begin
        vec_t tv[9];
        int   base, guard, start;
        logic acc;

        tv[0] = '{0, 461, 499, 847, 331, 591};
`ifdef BUTTERFLY_INTT_HALF_EN
        tv[1] = '{1, 461, 499, 847, 480, 552};
        tv[5] = '{1, 3328, 3328, 5, 3328, 0};
        tv[6] = '{1, 0, 1, 1, 1665, 1664};
`else
        tv[1] = '{1, 461, 499, 847, 960, 1104};
        tv[5] = '{1, 3328, 3328, 5, 3327, 0};
        tv[6] = '{1, 0, 1, 1, 1, 3328};
`endif
        tv[2] = '{0, 3328, 3328, 1, 3327, 0};
        tv[3] = '{2, 3328, 2, 3328, 1, 3327};
        tv[4] = '{3, 5, 7, 0, 5, 7};
        tv[7] = '{0, 10, 3000, 0, 10, 10};
        tv[8] = '{0, 0, 1, 1, 1, 3328};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_c", int'(c), 0);
        check("rst_d", int'(d), 0);
        check("rst_tag", int'(out_tag), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(tv[i], i);
        @(posedge clk); #1;

        // Ten tagged beats under a 1,0,0 out_ready pattern.
        base     = out_cnt;
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            drive(i % 4, rnd_op(), rnd_op(), rnd_op(), i);
            guard = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 50);
            if (!acc) check("stream_accept_timeout", guard, 0);
        end
        in_valid = 1'b0;
        drain("stream_drain");
        check("stream_count", out_cnt - base, 10);

        // Reset with three beats in flight.
        rdy_mode = 0;
        @(posedge clk); #1;
        drive(0, 461, 499, 847, 21);
        @(posedge clk); #1;
        drive(2, 100, 200, 300, 22);
        @(posedge clk); #1;
        drive(3, 9, 8, 7, 23);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_c", int'(c), 0);
        check("midrst_d", int'(d), 0);
        check("midrst_tag", int'(out_tag), 0);
        base = out_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_stale", out_cnt - base, 0);

        // Long random run with random in_valid and out_ready.
        rdy_mode = 2;
        start    = acc_cnt;
        guard    = 0;
        while (acc_cnt - start < 10000 && guard < 60000) begin
            drive(int'($urandom_range(0, 3)), rnd_op(), rnd_op(), rnd_op(), int'($urandom_range(0, 255)));
            in_valid = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        check("rand_sent", acc_cnt - start, 10000);
        rdy_mode = 0;
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
